seq_mult32: RTL and testbench
=============================

// Module: seq_mult32
// PURPOSE
//  Iterative shift-and-add unsigned multiplier feeding the ALU result-select mux
//  (mux2x1_2nd tree). Accepts two W-bit operands on a start strobe and computes the
//  2W-bit product over W clock cycles. Drives res_sel, which steers the downstream
//  mux to the multiplier result once the product is valid.
// PARAMETERS
//  W  32  operand width; product is 2*W bits; iteration counter is $clog2(W)+1 bits
// PORTS
//  clk      input   1     system clock; all state changes on rising edge
//  rst      input   1     asynchronous, active-high reset
//  start    input   1     start request; sampled only in IDLE or DONE
//  a        input   W     multiplicand; captured on the accepted start edge
//  b        input   W     multiplier; captured on the accepted start edge
//  busy     output  1     high while in RUN
//  done     output  1     one-cycle pulse; product is valid from this cycle on
//  product  output  2W    registered result; holds until the next completion
//  res_sel  output  1     select to downstream mux; 1 = product is valid
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; busy=0, done=0, res_sel=0, product=0,
//    and all internal regs (mcand, mplier, acc, count) cleared. Takes effect immediately,
//    mid-RUN included. No partial result reaches product.
//  FSM: IDLE, RUN, DONE.
//    IDLE: start=1 -> RUN. Capture mcand={W'b0,a}, mplier=b, acc=0, count=0.
//          start=0 -> stay in IDLE.
//    RUN:  each edge: if mplier[0] then acc <= acc + mcand (2W-bit add, no carry out).
//          Also mcand <= mcand<<1, mplier <= mplier>>1, count <= count+1.
//          When count==W-1 on an edge: the final iteration executes, then -> DONE.
//          product <= final acc in the same edge. start is ignored in RUN.
//    DONE: done=1 for exactly this cycle.
//          start=1 -> RUN with new operands (back-to-back; same capture as IDLE).
//          Otherwise -> IDLE.
//  Latency: start accepted at edge k -> done high in the cycle after edge k+W.
//    No early termination, even for zero operands. Throughput: one op per W+1 cycles.
//  busy = (state==RUN). done = (state==DONE). Both are decoded from registered state.
//  res_sel: set to 1 on the DONE-entry edge. Cleared to 0 on the edge that accepts a
//    new start, so the mux never selects a stale or partial product during RUN.
//  product updates only on DONE entry. Between operations it is stable.
//  Unsigned arithmetic only. Exact 2W-bit result, so overflow is impossible.
// TESTING
//  1. a=3, b=5, start pulse 1 cycle -> busy for 32 cycles. Then done=1 for one cycle,
//     product=64'd15, res_sel=1.
//  2. a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001.
//     Latency is 32 cycles from the start edge.
//  3. a=0, b=32'h1234 -> product=0 after the full 32-cycle latency.
//     done occurs exactly once.
//  4. During RUN of 7*9, pulse start with a=2, b=2 -> ignored; product=63.
//  5. In the DONE cycle of 6*7 (product=42), assert start with a=10, b=10.
//     -> res_sel drops and busy rises next cycle. Product becomes 100 after 32 cycles.
//  6. Assert rst mid-RUN (cycle 10 of 100*100) -> busy, done, res_sel and product
//     all 0 immediately. After release with start=0, the block stays in IDLE.

Source files
------------

// File: rtl/seq_mult32.sv
// Iterative shift-and-add unsigned multiplier: W-bit operands, 2W-bit product over W cycles.
// res_sel steers the downstream result mux to the product only once it is complete.
module seq_mult32 #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product,
  output logic             res_sel
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [2*W-1:0]   mcand;
  logic [2*W-1:0]   acc;
  logic [W-1:0]     mplier;
  logic [CW-1:0]    count;
  logic [2*W-1:0]   acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
      res_sel <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            mcand   <= {{W{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
            count   <= '0;
            res_sel <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // The last partial product is folded in on the same edge that publishes the result.
          if (count == LAST) begin
            state   <= DONE;
            product <= acc_next;
            res_sel <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult32.sv
// Randomised self-checking bench for seq_mult32; reference product is plain 64-bit multiplication.
module tb_seq_mult32;

  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;
  logic            res_sel;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult32 #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .res_sel(res_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx, yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  // Launch one operation and observe 40 cycles: latency to first done, busy/done counts, product.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cyc, output int done_cnt,
                        output logic [63:0] prod, output logic sel_at_done);
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; busy_cyc = 0; done_cnt = 0; prod = '0; sel_at_done = 1'b0;
    if (busy === 1'b1) busy_cyc++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        done_cnt++;
        if (lat < 0) begin
          lat = i;
          prod = product;
          sel_at_done = res_sel;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, res_sel} !== 3'b000 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b res_sel=%b product=%h, required 0 0 0 0",
               busy, done, res_sel, product);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, res_sel} !== 3'b000 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b res_sel=%b product=%h, required all 0",
               busy, done, res_sel, product);
    end
  endtask

  task automatic test_op(input string name, input logic [31:0] x, input logic [31:0] y);
    int lat, bc, dc;
    logic [63:0] p, exp_p;
    logic sel;
    exp_p = ref_mul(x, y);
    run_op(x, y, lat, bc, dc, p, sel);
    n_checks++;
    if (p !== exp_p) begin
      n_fail++;
      $display("FAIL %s product: got %h, required %h", name, p, exp_p);
    end
    n_checks++;
    if (lat !== W) begin
      n_fail++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, W);
    end
    n_checks++;
    if (bc !== W || dc !== 1) begin
      n_fail++;
      $display("FAIL %s busy/done counts: busy=%0d done=%0d, required %0d and 1", name, bc, dc, W);
    end
    n_checks++;
    if (sel !== 1'b1 || product !== exp_p) begin
      n_fail++;
      $display("FAIL %s res_sel/hold: res_sel=%b product=%h, required 1 and %h", name, sel, product, exp_p);
    end
  endtask

  task automatic test_start_ignored();
    int lat = -1;
    logic [63:0] p = '0;
    @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    // 6 edges consumed after the accept edge; keep counting from there.
    for (int i = 7; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && lat < 0) begin
        lat = i;
        p = product;
      end
    end
    n_checks++;
    if (p !== ref_mul(32'd7, 32'd9) || lat !== W) begin
      n_fail++;
      $display("FAIL start_ignored: product=%h latency=%0d, required %h and %0d",
               p, lat, ref_mul(32'd7, 32'd9), W);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, dc;
    logic [63:0] p;
    logic sel;
    // First op done; its final sample is 8 cycles after done, so use a fresh launch with explicit wait.
    @(negedge clk);
    start = 1'b1; a = 32'd6; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) lat = i;
    end
    n_checks++;
    if (lat !== W || product !== 64'd42 || res_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: latency=%0d product=%h res_sel=%b, required %0d 42 1",
               lat, product, res_sel, W);
    end
    start = 1'b1; a = 32'd10; b = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++;
    if (res_sel !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || product !== 64'd42) begin
      n_fail++;
      $display("FAIL b2b_restart: res_sel=%b busy=%b done=%b product=%h, required 0 1 0 42",
               res_sel, busy, done, product);
    end
    lat = -1; p = '0; dc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dc++;
        if (lat < 0) begin
          lat = i;
          p = product;
        end
      end
    end
    n_checks++;
    if (lat !== W || p !== 64'd100 || dc !== 1) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d product=%h done_cnt=%0d, required %0d 100 1",
               lat, p, dc, W);
    end
    bc = 0; sel = 1'b0;
  endtask

  task automatic test_mid_reset();
    int bad;
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd100;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, res_sel} !== 3'b000 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b res_sel=%b product=%h, required all 0",
               busy, done, res_sel, product);
    end
    @(negedge clk) rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || res_sel !== 1'b0 || product !== 64'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stay_idle: %0d cycles with activity after reset release, required 0", bad);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int k = 0; k < 12; k++) begin
      x = $urandom;
      y = $urandom;
      if (k == 0) y = 32'h8000_0000;
      if (k == 1) x = 32'h0000_0001;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      test_op("random", x, y);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_op("mul_3x5", 32'd3, 32'd5);
    test_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_op("mul_zero", 32'd0, 32'h1234);
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
